mesi_isc_breq_arb: RTL
======================

Name: mesi_isc_breq_arb

Overview:
Upstream feeder of the broadcast stage. Collects broadcast requests from the four CPU ports and holds up to one pending request per CPU. Arbitrates round-robin among pending requests, tags the winner with its CPU id and a rolling broadcast ID, and writes it into the broadcast FIFO. Throttles on the FIFO full flag.

Parameters:
ADDR_WIDTH, 32, request address width
BROAD_TYPE_WIDTH, 2, broadcast type width; the value is passed through unmodified
BROAD_ID_WIDTH, 5, broadcast ID width; the ID counter wraps at 2^BROAD_ID_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cpu_req_valid_i  input  4  per-CPU request valid; bit i = CPU i
cpu_req_addr_array_i  input  4*ADDR_WIDTH  CPU i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
cpu_req_type_array_i  input  4*BROAD_TYPE_WIDTH  CPU i type, sliced the same way
cpu_req_ack_o  output  4  per-CPU accept, combinational
broad_fifo_full_i  input  1  broadcast FIFO full status
broad_fifo_wr_o  output  1  FIFO write strobe, combinational
broad_addr_o  output  ADDR_WIDTH  address of the granted request
broad_type_o  output  BROAD_TYPE_WIDTH  type of the granted request
broad_cpu_id_o  output  2  index of the granted CPU
broad_id_o  output  BROAD_ID_WIDTH  broadcast ID attached to the write
arb_busy_o  output  1  at least one holding register is occupied

Behaviour:
- Reset (rst=0, asynchronous):
  - All hold_vld[3:0] = 0.
  - last_grant = 3, so CPU0 has first priority.
  - id_cnt = 0.
  - All outputs evaluate to 0: ack=0, wr=0, busy=0, data outputs 0.
- Holding registers: one per CPU, each storing addr, type and a valid bit hold_vld[i].
- Request handshake:
  - cpu_req_ack_o[i] = cpu_req_valid_i[i] & (~hold_vld[i] | grant[i]).
  - The CPU holds valid, addr and type stable until it sees ack.
  - On the edge where ack[i]=1, the holding register captures addr and type and hold_vld[i] becomes 1.
- Arbitration (combinational):
  - Candidates: hold_vld[i]=1.
  - Search order: (last_grant+1)%4, (last_grant+2)%4, (last_grant+3)%4, last_grant.
  - The first candidate found is the winner; at most one grant bit is set.
  - grant is forced to all-zero when broad_fifo_full_i=1.
- Issue:
  - broad_fifo_wr_o = |grant.
  - broad_addr_o and broad_type_o come from the winning holding register.
  - broad_cpu_id_o = winner index; broad_id_o = id_cnt.
  - When wr=0, all data outputs are 0.
- Updates on an issue edge:
  - hold_vld[winner] is cleared, unless it is refilled by a simultaneous ack to the same CPU, in which case it stays 1 with the new data.
  - last_grant = winner.
  - id_cnt = id_cnt + 1, modulo 2^BROAD_ID_WIDTH (31 -> 0 at default width).
- Latency: a request accepted at edge N can issue in the cycle after edge N, at the earliest.
- Throughput: one broadcast per cycle while the FIFO is not full.
- Full FIFO: no write, no pointer or ID change, and holding registers are retained. A new request is acked only if its holding register is empty.
- Simultaneous events: acks to other CPUs are independent of the grant. All four CPUs may be acked in the same cycle.
- Reset mid-operation: pending requests are discarded and not issued. The ID sequence restarts at 0.
- arb_busy_o = |hold_vld (registered state, not the next state).

Optional Feature:
Macro MESI_ISC_BREQ_ARB_STAT_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles where |hold_vld=1 and broad_fifo_full_i=1.
  - Saturates at 16'hFFFF; reset value 0.
  - Adds output max_id_o (BROAD_ID_WIDTH), the last issued broadcast ID; reset value 0.
- Not defined: neither port exists, no extra logic is built, and core behaviour is identical.

Test Plan:
1. Reset release, then CPU2 valid with addr=32'h0000_1000, type=2'b01 → ack[2] in that cycle; next cycle wr=1, cpu_id=2, id=0, addr=32'h1000; then busy=0.
2. All four CPUs valid in the same cycle, FIFO never full → four acks at once; writes over 4 consecutive cycles in order CPU0, 1, 2, 3 with ids 0, 1, 2, 3.
3. CPU1 and CPU3 request continuously while the FIFO is not full → alternating grants 1, 3, 1, 3; each CPU gets a new ack on its own grant cycle, giving back-to-back throughput.
4. full=1 for 5 cycles with CPU0 pending → wr=0 for those 5 cycles and id_cnt is unchanged; with the macro defined, stall_cnt_o=5. The write occurs in the first cycle after full deasserts.
5. Issue 33 requests → broad_id_o sequence 0..31, then 0.
6. Assert rst low while CPU0..3 are pending → busy=0 and wr=0 immediately, without waiting for a clock edge. The first request after release gets id=0 and CPU0 priority.

Source files
------------

// File: rtl/mesi_isc_breq_arb_if.sv
// Request/broadcast bundle for the broadcast-request arbiter.
// slave  : arbiter side. It consumes the CPU requests and the FIFO full flag,
//          and drives the acks and the FIFO write port.
// master : requester/FIFO side, the mirror image of slave.
// With MESI_ISC_BREQ_ARB_STAT_EN defined, the bundle also carries stall_cnt_o and max_id_o.
`timescale 1ns/1ps
interface mesi_isc_breq_arb_if #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5
);
    logic [3:0]                    cpu_req_valid_i;
    logic [4*ADDR_WIDTH-1:0]       cpu_req_addr_array_i;
    logic [4*BROAD_TYPE_WIDTH-1:0] cpu_req_type_array_i;
    logic [3:0]                    cpu_req_ack_o;
    logic                          broad_fifo_full_i;
    logic                          broad_fifo_wr_o;
    logic [ADDR_WIDTH-1:0]         broad_addr_o;
    logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o;
    logic [1:0]                    broad_cpu_id_o;
    logic [BROAD_ID_WIDTH-1:0]     broad_id_o;
    logic                          arb_busy_o;
`ifdef MESI_ISC_BREQ_ARB_STAT_EN
    logic [15:0]                   stall_cnt_o;
    logic [BROAD_ID_WIDTH-1:0]     max_id_o;
`endif

    modport slave (
        input  cpu_req_valid_i, cpu_req_addr_array_i, cpu_req_type_array_i, broad_fifo_full_i,
        output cpu_req_ack_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
               broad_cpu_id_o, broad_id_o, arb_busy_o
`ifdef MESI_ISC_BREQ_ARB_STAT_EN
        , output stall_cnt_o, max_id_o
`endif
    );

    modport master (
        output cpu_req_valid_i, cpu_req_addr_array_i, cpu_req_type_array_i, broad_fifo_full_i,
        input  cpu_req_ack_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
               broad_cpu_id_o, broad_id_o, arb_busy_o
`ifdef MESI_ISC_BREQ_ARB_STAT_EN
        , input stall_cnt_o, max_id_o
`endif
    );
endinterface

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast-request arbiter.
// It holds one pending request per CPU and grants the pending requests round-robin.
// Each winner is written to the broadcast FIFO together with its CPU id and a rolling broadcast id.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  mesi_isc_breq_arb_if.slave
//        CPU request valid/addr/type and ack; FIFO full flag, write strobe and data; busy flag
// Optional: MESI_ISC_BREQ_ARB_STAT_EN adds stall_cnt_o and max_id_o.
`timescale 1ns/1ps
module mesi_isc_breq_arb #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    mesi_isc_breq_arb_if.slave     bus
);
    localparam int unsigned NCPU = 4;

    logic [NCPU-1:0]             r_hold_vld;
    logic [ADDR_WIDTH-1:0]       r_hold_addr [NCPU];
    logic [BROAD_TYPE_WIDTH-1:0] r_hold_type [NCPU];
    logic [1:0]                  r_last_grant;
    logic [BROAD_ID_WIDTH-1:0]   r_id_cnt;

    logic                        w_found;
    logic [1:0]                  w_win;
    logic [NCPU-1:0]             w_grant;
    logic [NCPU-1:0]             w_ack;

    // Round-robin search that starts just after the last winner. The FIFO full flag masks the grant.
    always_comb begin : arb
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_win   = 2'd0;
        v_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last_grant + 2'(k);
            if (!w_found && r_hold_vld[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
        if (bus.broad_fifo_full_i) begin
            w_found = 1'b0;
        end
    end

    assign w_grant = w_found ? (4'b0001 << w_win) : 4'b0000;

    // A holding register can accept a request when it is empty or is being drained this cycle.
    // The ack is held low while reset is asserted.
    assign w_ack = rst ? (bus.cpu_req_valid_i & (~r_hold_vld | w_grant)) : 4'b0000;

    // Capture data on ack and drain the register on grant. A simultaneous ack refills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_vld   <= '0;
            r_last_grant <= 2'd3;
            r_id_cnt     <= '0;
            for (int i = 0; i < NCPU; i++) begin
                r_hold_addr[i] <= '0;
                r_hold_type[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCPU; i++) begin
                if (w_ack[i]) begin
                    r_hold_vld[i]  <= 1'b1;
                    r_hold_addr[i] <= bus.cpu_req_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_hold_type[i] <= bus.cpu_req_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
                end else if (w_grant[i]) begin
                    r_hold_vld[i]  <= 1'b0;
                end
            end
            if (w_found) begin
                r_last_grant <= w_win;
                r_id_cnt     <= r_id_cnt + BROAD_ID_WIDTH'(1);
            end
        end
    end

    assign bus.cpu_req_ack_o   = w_ack;
    assign bus.broad_fifo_wr_o = w_found;
    assign bus.broad_addr_o    = w_found ? r_hold_addr[w_win] : '0;
    assign bus.broad_type_o    = w_found ? r_hold_type[w_win] : '0;
    assign bus.broad_cpu_id_o  = w_found ? w_win : 2'd0;
    assign bus.broad_id_o      = w_found ? r_id_cnt : '0;
    assign bus.arb_busy_o      = |r_hold_vld;

`ifdef MESI_ISC_BREQ_ARB_STAT_EN
    logic [15:0]               r_stall_cnt;
    logic [BROAD_ID_WIDTH-1:0] r_max_id;

    // Count the cycles in which work is pending but the FIFO blocks it (saturating).
    // Also keep the id of the most recent issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_max_id    <= '0;
        end else begin
            if ((|r_hold_vld) && bus.broad_fifo_full_i && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_found) begin
                r_max_id <= r_id_cnt;
            end
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.max_id_o    = r_max_id;
`endif
endmodule
